fetch_queue_nw: RTL

- Parametrised N-wide fetch front end: PC register, N-slot instruction cache and predictor interface, and a circular fetch queue feeding decode.
- Replaces the fixed two-slot fetch stage, which had no buffering. Fetched bundles are cut at the first predicted-taken slot and then enqueued.
- Decode pops 0..FETCH_W entries per cycle. A redirect from decode or execute flushes the queue and reloads the PC.

---
 rtl/fetch_queue_nw.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/fetch_queue_nw.sv
// fetch_queue_nw: N-wide fetch front end with a PC register, a taken-branch
// bundle cut and a circular fetch queue feeding decode.
// Optional feature: define FQ_PERF_EN to add saturating performance counters.
module fetch_queue_nw #(
   parameter int unsigned      WIDTH    = 32,
   parameter int unsigned      FETCH_W  = 2,
   parameter int unsigned      QDEPTH   = 8,
   parameter logic [WIDTH-1:0] RESET_PC = '0
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic                                stall_F,
   input  logic                                redirect_valid,
   input  logic [WIDTH-1:0]                    redirect_pc,
   output logic [WIDTH-1:0]                    imem_addr,
   input  logic [FETCH_W*WIDTH-1:0]            imem_rdata,
   input  logic [FETCH_W-1:0]                  bp_hit,
   input  logic [FETCH_W-1:0]                  bp_taken,
   input  logic [FETCH_W*WIDTH-1:0]            bp_target,
   input  logic [$clog2(FETCH_W+1)-1:0]        deq_cnt,
   output logic [FETCH_W-1:0]                  deq_valid,
   output logic [FETCH_W*(2+2*WIDTH)-1:0]      deq_entry,
   output logic [$clog2(QDEPTH+1)-1:0]         q_count,
   output logic                                fetch_full
`ifdef FQ_PERF_EN
   ,
   output logic [31:0]                         perf_full_cycles,
   output logic [31:0]                         perf_redirects,
   output logic [31:0]                         perf_taken_cuts
`endif
);

   localparam int unsigned CW = $clog2(FETCH_W + 1);
   localparam int unsigned QW = $clog2(QDEPTH + 1);
   localparam int unsigned AW = $clog2(QDEPTH);
   localparam int unsigned EW = 2 + 2 * WIDTH;

   // QDEPTH must be a power of two so pointer wrap is a plain truncation.
   logic [WIDTH-1:0] r_pc;
   logic [AW-1:0]    r_head;
   logic [AW-1:0]    r_tail;
   logic [QW-1:0]    r_count;
   logic [EW-1:0]    r_mem [QDEPTH];

   logic [CW-1:0]    w_k;
   logic             w_cut_taken;
   logic [WIDTH-1:0] w_tgt;
   logic [CW-1:0]    w_enq_n;
   logic [QW-1:0]    w_free;
   logic             w_space_ok;
   logic             w_enq;
   logic [QW-1:0]    w_pop_n;
   logic [WIDTH-1:0] w_pc_n;
   logic [AW-1:0]    w_head_n;
   logic [AW-1:0]    w_tail_n;
   logic [QW-1:0]    w_count_n;

   // Cut point: lowest predicted-taken slot, else the whole bundle
   always_comb begin
      w_k         = CW'(FETCH_W - 1);
      w_cut_taken = 1'b0;
      w_tgt       = '0;
      for (int i = int'(FETCH_W) - 1; i >= 0; i--) begin
         if (bp_hit[i] && bp_taken[i]) begin
            w_k         = CW'(i);
            w_cut_taken = 1'b1;
            w_tgt       = bp_target[i*WIDTH +: WIDTH];
         end
      end
   end

   // Enqueue/pop qualification; free space uses pre-pop occupancy
   always_comb begin
      w_enq_n    = w_k + CW'(1);
      w_free     = QW'(QDEPTH) - r_count;
      w_space_ok = (w_free >= QW'(FETCH_W));
      w_enq      = !redirect_valid && !stall_F && w_space_ok;
      w_pop_n    = (QW'(deq_cnt) > r_count) ? r_count : QW'(deq_cnt);
   end

   // Next-state for PC and queue pointers; redirect flushes and wins
   always_comb begin
      w_pc_n    = r_pc;
      w_head_n  = r_head;
      w_tail_n  = r_tail;
      w_count_n = r_count;
      if (redirect_valid) begin
         w_pc_n    = redirect_pc;
         w_head_n  = '0;
         w_tail_n  = '0;
         w_count_n = '0;
      end else begin
         w_head_n  = r_head + AW'(w_pop_n);
         w_count_n = r_count + QW'(w_enq_n & {CW{w_enq}}) - w_pop_n;
         if (w_enq) begin
            w_tail_n = r_tail + AW'(w_enq_n);
            w_pc_n   = w_cut_taken ? w_tgt : (r_pc + WIDTH'(4 * FETCH_W));
         end
      end
   end

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pc    <= RESET_PC;
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         r_pc    <= w_pc_n;
         r_head  <= w_head_n;
         r_tail  <= w_tail_n;
         r_count <= w_count_n;
      end
   end

   // Queue storage write of slots 0..k; storage is intentionally not reset
   always_ff @(posedge clk) begin
      if (w_enq) begin
         for (int i = 0; i < int'(FETCH_W); i++) begin
            if (CW'(i) <= w_k) begin
               r_mem[AW'(r_tail + AW'(i))] <= {bp_hit[i], bp_taken[i],
                                               r_pc + WIDTH'(4 * i),
                                               imem_rdata[i*WIDTH +: WIDTH]};
            end
         end
      end
   end

   // Head window to decode, oldest in slot 0
   for (genvar g = 0; g < int'(FETCH_W); g++) begin : g_head
      assign deq_valid[g]           = (r_count > QW'(g));
      assign deq_entry[g*EW +: EW]  = r_mem[AW'(r_head + AW'(g))];
   end

   assign imem_addr  = r_pc;
   assign q_count    = r_count;
   assign fetch_full = !w_space_ok;

`ifdef FQ_PERF_EN
   logic [31:0] r_perf_full;
   logic [31:0] r_perf_redir;
   logic [31:0] r_perf_cuts;

   // Saturating event counters
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_perf_full  <= '0;
         r_perf_redir <= '0;
         r_perf_cuts  <= '0;
      end else begin
         if (!redirect_valid && !stall_F && !w_space_ok && (r_perf_full != '1))
            r_perf_full <= r_perf_full + 32'd1;
         if (redirect_valid && (r_perf_redir != '1))
            r_perf_redir <= r_perf_redir + 32'd1;
         if (w_enq && w_cut_taken && (r_perf_cuts != '1))
            r_perf_cuts <= r_perf_cuts + 32'd1;
      end
   end

   assign perf_full_cycles = r_perf_full;
   assign perf_redirects   = r_perf_redir;
   assign perf_taken_cuts  = r_perf_cuts;
`endif

endmodule
